hc595_shift: RTL and testbench

HC595_SHIFT -- requirements
Module: hc595_shift

---
 rtl/hc595_if.sv | 22 ++
 rtl/hc595_shift.sv | 135 +++++++++++++
 tb/tb_hc595_shift.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc595_if.sv
// Pin bundle between the segment-scan stage and the 74HC595 serialiser.
// The scan stage drives sel/seg/en; the serialiser drives the chain pins.
interface hc595_if;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       en;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe;
    logic       frame_done;

    modport master (
        output sel, seg, en,
        input  ds, shcp, stcp, oe, frame_done
    );

    modport slave (
        input  sel, seg, en,
        output ds, shcp, stcp, oe, frame_done
    );
endinterface

// File: rtl/hc595_shift.sv
// Serialises a 14-bit {seg, sel} word MSB first into a 74HC595 chain,
// then pulses the storage clock; repeats every frame while en is high.
module hc595_shift #(
    parameter logic [15:0] SHCP_HALF = 16'd2
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    hc595_if.slave pins
);

    localparam int unsigned WORD_W = 14;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 4;

    localparam logic [CNT_W-1:0] HALF_LAST = SHCP_HALF - 16'd1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    state_t              state_q, state_n;
    logic [WORD_W-1:0]   word_q, word_n;
    logic [CNT_W-1:0]    half_q, half_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic                ds_q, ds_n;
    logic                shcp_q, shcp_n;
    logic                stcp_q, stcp_n;
    logic                oe_q;
    logic                done_q, done_n;

    // State and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            word_q  <= word_n;
            half_q  <= half_n;
            bit_q   <= bit_n;
            ds_q    <= ds_n;
            shcp_q  <= shcp_n;
            stcp_q  <= stcp_n;
            oe_q    <= 1'b0;
            done_q  <= done_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n = state_q;
        word_n  = word_q;
        half_n  = half_q;
        bit_n   = bit_q;
        ds_n    = ds_q;
        shcp_n  = shcp_q;
        stcp_n  = stcp_q;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                shcp_n = 1'b0;
                stcp_n = 1'b0;
                if (pins.en) begin
                    state_n = LOAD;
                end
            end

            LOAD: begin
                word_n  = {pins.seg, pins.sel};
                ds_n    = pins.seg[7];
                shcp_n  = 1'b0;
                stcp_n  = 1'b0;
                half_n  = '0;
                bit_n   = '0;
                state_n = SHIFT;
            end

            // ds only moves on the falling shcp edge, keeping it centred on the rise
            SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_n = '0;
                    if (!shcp_q) begin
                        shcp_n = 1'b1;
                    end else begin
                        shcp_n = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            stcp_n  = 1'b1;
                            state_n = LATCH;
                        end else begin
                            bit_n  = bit_q + 4'd1;
                            ds_n   = word_q[WORD_W-2];
                            word_n = {word_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    half_n = half_q + 16'd1;
                end
            end

            LATCH: begin
                if (half_q == HALF_LAST) begin
                    half_n  = '0;
                    stcp_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = pins.en ? LOAD : IDLE;
                end else begin
                    half_n = half_q + 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pins.ds         = ds_q;
    assign pins.shcp       = shcp_q;
    assign pins.stcp       = stcp_q;
    assign pins.oe         = oe_q;
    assign pins.frame_done = done_q;

endmodule

// File: tb/tb_hc595_shift.sv
// Bench for hc595_shift: two instances (half-period 2 and 1) checked every
// cycle against a frame-position model, plus directed scenarios and random traffic.
module tb_hc595_shift;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 sys_clk = ~sys_clk;

    hc595_if bus_h2 ();
    hc595_if bus_h1 ();

    assign bus_h2.sel = sel;
    assign bus_h2.seg = seg;
    assign bus_h2.en  = en;
    assign bus_h1.sel = sel;
    assign bus_h1.seg = seg;
    assign bus_h1.en  = en;

    hc595_shift #(.SHCP_HALF(16'd2)) dut_h2 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pins    (bus_h2.slave)
    );

    hc595_shift #(.SHCP_HALF(16'd1)) dut_h1 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pins    (bus_h1.slave)
    );

    // {ds, shcp, stcp, oe, frame_done}
    logic [4:0] obs [2];
    assign obs[0] = {bus_h2.ds, bus_h2.shcp, bus_h2.stcp, bus_h2.oe, bus_h2.frame_done};
    assign obs[1] = {bus_h1.ds, bus_h1.shcp, bus_h1.stcp, bus_h1.oe, bus_h1.frame_done};

    function automatic int half_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Reference model: position within a frame (-1 = idle), captured word, held ds
    int          m_pos [2];
    logic [13:0] m_w   [2];
    logic        m_ds  [2];
    logic        m_oe  [2];
    logic        m_fd  [2];

    // Protocol monitor state
    logic        p_ds [2], p_shcp [2], p_stcp [2], hold_ok [2], fd_seen [2];
    int          since [2], hi_cnt [2], st_cnt [2], nrise [2];
    int          tot_rise [2], tot_stcp [2], last_fd [2], fd_gap [2];
    logic [13:0] got_bits [2], last_bits [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] model_out(input int d);
        int   h = half_of(d);
        int   p = m_pos[d];
        int   q;
        int   bitn;
        logic ds = m_ds[d];
        logic sh = 1'b0;
        logic st = 1'b0;
        logic [13:0] w = m_w[d];
        if (p >= 1 && p <= 28 * h) begin
            q    = p - 1;
            bitn = q / (2 * h);
            ds   = w[13 - bitn];
            sh   = ((q % (2 * h)) >= h);
        end else if (p > 28 * h) begin
            ds = w[0];
            st = 1'b1;
        end
        return {ds, sh, st, m_oe[d], m_fd[d]};
    endfunction

    task automatic reset_model(input int d);
        m_pos[d] = -1;
        m_w[d]   = '0;
        m_ds[d]  = 1'b0;
        m_oe[d]  = 1'b1;
        m_fd[d]  = 1'b0;
    endtask

    task automatic step_model(input int d);
        int         flen = 29 * half_of(d) + 1;
        logic [4:0] o;
        m_oe[d] = 1'b0;
        m_fd[d] = 1'b0;
        if (m_pos[d] < 0) begin
            if (en) m_pos[d] = 0;
        end else if (m_pos[d] == 0) begin
            m_w[d]   = {seg, sel};
            m_pos[d] = 1;
        end else if (m_pos[d] == flen - 1) begin
            m_fd[d]  = 1'b1;
            m_pos[d] = en ? 0 : -1;
        end else begin
            m_pos[d] = m_pos[d] + 1;
        end
        o       = model_out(d);
        m_ds[d] = o[4];
    endtask

    task automatic reset_mon(input int d);
        p_ds[d]     = 1'b0;
        p_shcp[d]   = 1'b0;
        p_stcp[d]   = 1'b0;
        hold_ok[d]  = 1'b1;
        since[d]    = 0;
        hi_cnt[d]   = 0;
        st_cnt[d]   = 0;
        nrise[d]    = 0;
        got_bits[d] = '0;
        last_fd[d]  = -1;
    endtask

    task automatic monitor(input int d);
        logic [4:0] o  = obs[d];
        logic       ds = o[4];
        logic       sh = o[3];
        logic       st = o[2];
        int         h  = half_of(d);
        if (ds == p_ds[d]) since[d]++; else since[d] = 0;
        if (sh && p_shcp[d] && ds != p_ds[d]) hold_ok[d] = 1'b0;
        if (sh && !p_shcp[d]) begin
            check($sformatf("ds_setup_h%0d", h), 32'(since[d] >= h), 32'd1);
            got_bits[d] = {got_bits[d][12:0], ds};
            nrise[d]++;
            tot_rise[d]++;
            hi_cnt[d] = 1;
        end else if (sh) begin
            hi_cnt[d]++;
        end
        if (!sh && p_shcp[d]) begin
            check($sformatf("ds_hold_h%0d", h), 32'(hold_ok[d]), 32'd1);
            check($sformatf("shcp_high_h%0d", h), 32'(hi_cnt[d]), 32'(h));
            hold_ok[d] = 1'b1;
        end
        if (st && !p_stcp[d]) begin
            check($sformatf("rises_per_frame_h%0d", h), 32'(nrise[d]), 32'd14);
            check($sformatf("frame_bits_h%0d", h), 32'(got_bits[d]), 32'(m_w[d]));
            last_bits[d] = got_bits[d];
            nrise[d]     = 0;
            tot_stcp[d]++;
            st_cnt[d] = 1;
        end else if (st) begin
            st_cnt[d]++;
        end
        if (!st && p_stcp[d]) check($sformatf("stcp_width_h%0d", h), 32'(st_cnt[d]), 32'(h));
        if (o[0]) begin
            fd_seen[d] = 1'b1;
            if (last_fd[d] >= 0) fd_gap[d] = cyc - last_fd[d];
            last_fd[d] = cyc;
        end
        p_ds[d]   = ds;
        p_shcp[d] = sh;
        p_stcp[d] = st;
    endtask

    // One clock: advance the model at the edge, compare pins on the falling edge
    task automatic tick();
        @(posedge sys_clk);
        cyc++;
        for (int d = 0; d < 2; d++) if (!sys_rst) step_model(d);
        @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("pins_h%0d", half_of(d)), 32'(obs[d]), 32'(model_out(d)));
            monitor(d);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async_rst_pins_h%0d", half_of(d)), 32'(obs[d]), 32'h02);
            reset_model(d);
            reset_mon(d);
        end
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_rise(input int d, input int n);
        int b = 0;
        while (nrise[d] < n && b < 400) begin
            tick();
            b++;
        end
        check("wait_rise", 32'(nrise[d] >= n), 32'd1);
    endtask

    task automatic wait_fd(input int d);
        int b = 0;
        fd_seen[d] = 1'b0;
        while (!fd_seen[d] && b < 400) begin
            tick();
            b++;
        end
        check("wait_frame_done", 32'(fd_seen[d]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, s0;
        sys_rst = 1'b1;
        sel     = '0;
        seg     = '0;
        en      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reset_model(d);
            reset_mon(d);
            tot_rise[d]  = 0;
            tot_stcp[d]  = 0;
            fd_gap[d]    = 0;
            last_bits[d] = '0;
            fd_seen[d]   = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) check("reset_pins", 32'(obs[d]), 32'h02);
        sys_rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) check("oe_after_release", 32'(obs[d][1]), 32'd0);

        // Basic frame: C0 / 111110
        seg = 8'hC0;
        sel = 6'b111110;
        en  = 1'b1;
        wait_fd(0);
        check("basic_bits", 32'(last_bits[0]), 32'h303E);

        // Continuous frames: fixed period
        wait_fd(0);
        wait_fd(0);
        check("period_h2", 32'(fd_gap[0]), 32'd59);
        check("period_h1", 32'(fd_gap[1]), 32'd30);

        // Input change during SHIFT only affects the next frame
        wait_rise(0, 3);
        seg = 8'hF9;
        wait_fd(0);
        check("chg_current_frame", 32'(last_bits[0]), 32'h303E);
        wait_fd(0);
        check("chg_next_frame", 32'(last_bits[0]), 32'h3E7E);

        // en dropped at bit 5: frame completes, then silence
        wait_rise(0, 5);
        en = 1'b0;
        wait_fd(0);
        check("drop_bits", 32'(last_bits[0]), 32'h3E7E);
        r0 = tot_rise[0];
        s0 = tot_stcp[0];
        repeat (40) tick();
        check("idle_rises", 32'(tot_rise[0] - r0), 32'd0);
        check("idle_stcp", 32'(tot_stcp[0] - s0), 32'd0);
        check("idle_clocks", 32'(obs[0][3:2]), 32'd0);

        // Reset at bit 7: no latch for the aborted frame
        en = 1'b1;
        wait_rise(0, 7);
        s0 = tot_stcp[0];
        do_reset();
        wait_fd(0);
        check("post_rst_stcp", 32'(tot_stcp[0] - s0), 32'd1);
        check("post_rst_bits", 32'(last_bits[0]), 32'h3E7E);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 4 == 0) begin
                sel = 6'($urandom);
                seg = 8'($urandom);
            end
            if ($urandom % 97 == 0) en = ~en;
            if ($urandom % 1500 == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
